// File: rtl/chunked_seq_adder.sv
// ---------------------------------------------------------------------------
// chunked_seq_adder
//   Multi-cycle adder/subtractor. Adds WIDTH-bit operands CHUNK bits per
//   clock, LSB slice first, carrying between slices through a register.
//   Subtract is A + ~B + 1, so carry=1 means "no borrow".
//   WIDTH must be an integer multiple of CHUNK (1 <= CHUNK <= WIDTH).
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   start    in   request a new operation (ignored while busy)
//   a, b     in   operands, sampled with start
//   cin      in   carry-in, sampled with start (ignored when sub=1)
//   sub      in   0: a+b+cin, 1: a-b
//   busy     out  high while slices are being computed
//   done     out  one-cycle pulse when sum/carry/overflow are valid
//   sum      out  result modulo 2^WIDTH, held until the next accepted start
//   carry    out  carry out of the MSB
//   overflow out  two's-complement overflow
// ---------------------------------------------------------------------------
module chunked_seq_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;        // already inverted for subtract
  logic             c_q, c_d;        // carry between slices
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Current slice operands and their CHUNK+1-bit sum
  logic [31:0]      base;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   slice_sum;
  logic             msb_cin;

  always_comb begin
    base      = 32'(idx_q) * 32'(CHUNK);
    a_sl      = CHUNK'(a_q >> base);
    b_sl      = CHUNK'(b_q >> base);
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK+1)'(c_q);
    // Carry into the top bit recovered from the operand and result bits
    msb_cin   = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ slice_sum[CHUNK-1];
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        // Replace only this slice of the result; other bits are untouched
        sum_d = (sum_q & ~(SLICE_MASK << base))
              | ((WIDTH'(slice_sum[CHUNK-1:0]) & SLICE_MASK) << base);
        c_d   = slice_sum[CHUNK];
        if (idx_q == LAST_IDX) begin
          carry_d = slice_sum[CHUNK];
          ovf_d   = msb_cin ^ slice_sum[CHUNK];
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_chunked_seq_adder
//   Four instances: 8/4, 32/8, 8/1, 8/8. Directed vectors with hand-computed
//   results plus hand-written back-to-back and mid-operation reset sequences.
// ---------------------------------------------------------------------------
module tb_chunked_seq_adder;

  localparam int LAT [4] = '{2, 4, 8, 1};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_r [4];
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic        cin, sub;

  logic        busy_w [4];
  logic        done_w [4];
  logic        carry_w [4];
  logic        ovf_w [4];
  logic [31:0] sum_w [4];
  logic [7:0]  sum0, sum2, sum3;
  logic [31:0] sum1;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  chunked_seq_adder #(.WIDTH(8), .CHUNK(4)) u_8x4 (
    .clk(clk), .rst(rst), .start(start_r[0]), .a(a8), .b(b8), .cin(cin), .sub(sub),
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum0), .carry(carry_w[0]), .overflow(ovf_w[0]));
  chunked_seq_adder #(.WIDTH(32), .CHUNK(8)) u_32x8 (
    .clk(clk), .rst(rst), .start(start_r[1]), .a(a32), .b(b32), .cin(cin), .sub(sub),
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum1), .carry(carry_w[1]), .overflow(ovf_w[1]));
  chunked_seq_adder #(.WIDTH(8), .CHUNK(1)) u_8x1 (
    .clk(clk), .rst(rst), .start(start_r[2]), .a(a8), .b(b8), .cin(cin), .sub(sub),
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum2), .carry(carry_w[2]), .overflow(ovf_w[2]));
  chunked_seq_adder #(.WIDTH(8), .CHUNK(8)) u_8x8 (
    .clk(clk), .rst(rst), .start(start_r[3]), .a(a8), .b(b8), .cin(cin), .sub(sub),
    .busy(busy_w[3]), .done(done_w[3]), .sum(sum3), .carry(carry_w[3]), .overflow(ovf_w[3]));

  assign sum_w[0] = 32'(sum0);
  assign sum_w[1] = sum1;
  assign sum_w[2] = 32'(sum2);
  assign sum_w[3] = 32'(sum3);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic set_ops(input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic su);
    a32 = av;
    b32 = bv;
    a8  = av[7:0];
    b8  = bv[7:0];
    cin = ci;
    sub = su;
  endtask

  task automatic set_garbage();
    set_ops($urandom, $urandom, 1'($urandom), 1'($urandom));
  endtask

  // One operation on instance d; start is also held during the first RUN
  // cycle and operands are scrambled after sampling, neither may matter.
  task automatic do_op(input int d, input vec_t v, input string nm);
    int n;
    int nbusy;
    @(negedge clk);
    set_ops(v.a, v.b, v.cin, v.sub);
    start_r[d] = 1'b1;
    @(negedge clk);
    set_garbage();
    n     = 0;
    nbusy = 0;
    while (!done_w[d] && n < LAT[d] + 4) begin
      if (busy_w[d]) nbusy++;
      @(negedge clk);
      n++;
      start_r[d] = 1'b0;
      set_garbage();
    end
    chk({nm, " latency"}, 32'(n), 32'(LAT[d]));
    chk({nm, " sum"}, sum_w[d], v.s);
    chk({nm, " carry"}, 32'(carry_w[d]), 32'(v.c));
    chk({nm, " overflow"}, 32'(ovf_w[d]), 32'(v.o));
    chk({nm, " busy_at_done"}, 32'(busy_w[d]), 32'd0);
    chk({nm, " busy_cycles"}, 32'(nbusy), 32'(LAT[d]));
    @(negedge clk);
    chk({nm, " done_pulse"}, 32'(done_w[d]), 32'd0);
    chk({nm, " sum_hold"}, sum_w[d], v.s);
  endtask

  initial begin
    vec_t tbl [10];
    vec_t b2b [3];
    vec_t v;
    logic seen_done;

    // a, b, cin, sub, sum, carry, overflow (8-bit, hand computed)
    tbl[0] = '{32'd100, 32'd100, 1'b1, 1'b0, 32'd201, 1'b0, 1'b1};
    tbl[1] = '{32'd200, 32'd200, 1'b0, 1'b0, 32'd144, 1'b1, 1'b0};
    tbl[2] = '{32'd20,  32'd200, 1'b0, 1'b0, 32'd220, 1'b0, 1'b0};
    tbl[3] = '{32'd30,  32'd200, 1'b0, 1'b0, 32'd230, 1'b0, 1'b0};
    tbl[4] = '{32'd40,  32'd200, 1'b1, 1'b0, 32'd241, 1'b0, 1'b0};
    tbl[5] = '{32'd50,  32'd200, 1'b0, 1'b0, 32'd250, 1'b0, 1'b0};
    tbl[6] = '{32'd50,  32'd90,  1'b1, 1'b0, 32'd141, 1'b0, 1'b1};
    tbl[7] = '{32'd50,  32'd80,  1'b0, 1'b0, 32'd130, 1'b0, 1'b1};
    tbl[8] = '{32'd50,  32'd70,  1'b0, 1'b0, 32'd120, 1'b0, 1'b0};
    tbl[9] = '{32'd60,  32'd200, 1'b0, 1'b0, 32'd4,   1'b1, 1'b0};

    b2b[0] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    b2b[1] = '{32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0};
    b2b[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    rst = 1'b1;
    for (int d = 0; d < 4; d++) start_r[d] = 1'b0;
    set_ops(32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset%0d busy", d), 32'(busy_w[d]), 32'd0);
      chk($sformatf("reset%0d done", d), 32'(done_w[d]), 32'd0);
      chk($sformatf("reset%0d sum", d), sum_w[d], 32'd0);
      chk($sformatf("reset%0d carry", d), 32'(carry_w[d]), 32'd0);
      chk($sformatf("reset%0d ovf", d), 32'(ovf_w[d]), 32'd0);
    end
    rst = 1'b0;

    // 8/4: add with overflow, add with carry, subtract with borrow
    do_op(0, tbl[0], "t1");
    do_op(0, tbl[1], "t2a");
    v = '{32'd50, 32'd80, 1'b1, 1'b1, 32'd226, 1'b0, 1'b0};
    do_op(0, v, "t2b");

    // 32/8: full carry ripple and positive overflow
    v = '{32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0};
    do_op(1, v, "t3a");
    v = '{32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    do_op(1, v, "t3b");

    // Bit-serial and single-cycle sweeps
    for (int i = 0; i < 10; i++) begin
      do_op(2, tbl[i], $sformatf("t6_c1_%0d", i));
      do_op(3, tbl[i], $sformatf("t6_c8_%0d", i));
    end

    // Back-to-back: start held high, operands scrambled during RUN
    @(negedge clk);
    set_ops(b2b[0].a, b2b[0].b, b2b[0].cin, b2b[0].sub);
    start_r[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 5; n++) begin
        @(negedge clk);
        if (n < 4) begin
          if (n == 3) chk($sformatf("t4_%0d done_early", k), 32'(done_w[1]), 32'd0);
          set_garbage();
        end else begin
          chk($sformatf("t4_%0d done", k), 32'(done_w[1]), 32'd1);
          chk($sformatf("t4_%0d sum", k), sum_w[1], b2b[k].s);
          chk($sformatf("t4_%0d carry", k), 32'(carry_w[1]), 32'(b2b[k].c));
          chk($sformatf("t4_%0d ovf", k), 32'(ovf_w[1]), 32'(b2b[k].o));
          if (k < 2) set_ops(b2b[k+1].a, b2b[k+1].b, b2b[k+1].cin, b2b[k+1].sub);
          else start_r[1] = 1'b0;
        end
      end
    end

    // Asynchronous reset during the third RUN cycle
    @(negedge clk);
    set_ops(32'h1122_3344, 32'h1111_1111, 1'b0, 1'b0);
    start_r[1] = 1'b1;
    @(negedge clk);
    start_r[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5 busy_before", 32'(busy_w[1]), 32'd1);
    chk("t5 partial_sum", sum_w[1], 32'h0000_4455);
    #1 rst = 1'b1;
    #1;
    chk("t5 busy_rst", 32'(busy_w[1]), 32'd0);
    chk("t5 done_rst", 32'(done_w[1]), 32'd0);
    chk("t5 sum_rst", sum_w[1], 32'd0);
    chk("t5 carry_rst", 32'(carry_w[1]), 32'd0);
    chk("t5 ovf_rst", 32'(ovf_w[1]), 32'd0);
    #1 rst = 1'b0;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen_done = seen_done | done_w[1];
    end
    chk("t5 no_done_after_rst", 32'(seen_done), 32'd0);
    v = '{32'h1122_3344, 32'h1111_1111, 1'b0, 1'b0, 32'h2233_4455, 1'b0, 1'b0};
    do_op(1, v, "t5_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/chunked_seq_adder.md
Name: chunked_seq_adder

Overview:
- Parametrised multi-cycle adder/subtractor.
- Adds two WIDTH-bit operands plus carry-in, one CHUNK-bit slice per clock, LSB slice first, using a registered carry between slices.
- Successor to the fixed 8-bit combinational adder. Adds width generality, a subtract mode, signed-overflow detection and a start/busy/done handshake.
- Used wherever wide arithmetic must trade latency for adder area.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle. Legal range 1..WIDTH.
- NCHUNK, WIDTH/CHUNK, derived number of slices. Local, not overridable.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request new operation. Sampled on rising clk.
- a  input  WIDTH  operand A. Sampled with start.
- b  input  WIDTH  operand B. Sampled with start.
- cin  input  1  carry-in. Sampled with start. Ignored when sub=1.
- sub  input  1  0: A+B+cin. 1: A-B, computed as A + ~B + 1.
- busy  output  1  high while slices are being computed
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  result, modulo 2^WIDTH
- carry  output  1  carry out of MSB. For sub: 1 = no borrow.
- overflow  output  1  two's-complement overflow (carry into MSB XOR carry out)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry=0, overflow=0, slice index=0, internal carry=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 on an edge latches a, and b (or ~b if sub).
  - Internal carry is set to cin (or 1 if sub). Index=0. Go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - busy=1.
  - Each edge adds slice[index] of A and B' plus the internal carry.
  - The CHUNK-bit result is written into sum[index*CHUNK +: CHUNK]; carry-out goes to the internal carry.
  - On the last slice (index=NCHUNK-1):
    - carry <= slice carry-out.
    - overflow <= carry into bit WIDTH-1 XOR carry-out.
    - Go to DONE.
  - Otherwise index increments.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - Next edge: if start=1, behave as IDLE accepting a new operation (back-to-back, no bubble). Else go to IDLE.
- Latency:
  - start sampled at edge E0.
  - done is high in the cycle following edge E0+NCHUNK.
  - Throughput: one result per NCHUNK+1 cycles.
- start while busy (RUN): ignored. Operands and mode of the in-flight operation are unaffected. No queuing.
- Input independence: a/b/cin/sub may change freely after the sampling edge. Only latched copies are used.
- Output hold:
  - sum/carry/overflow hold their values after done until the next accepted start.
  - sum bits are overwritten slice by slice during RUN, so sum is valid only from done onward.
- carry and overflow update only on the last slice.
- Reset mid-operation: immediate return to reset values. The partial result is discarded and no done is issued.
- CHUNK=WIDTH: NCHUNK=1, a single RUN cycle.
- CHUNK=1: bit-serial, WIDTH RUN cycles.
- Arithmetic: all slices are unsigned CHUNK+1-bit additions; no saturation. Result is modulo 2^WIDTH.

Test Plan:
1. WIDTH=8, CHUNK=4: a=100, b=100, cin=1, sub=0, pulse start → done exactly 2 cycles after the start edge. sum=201, carry=0, overflow=1. busy high for 2 cycles.
2. WIDTH=8, CHUNK=4: a=200, b=200, cin=0 → sum=144, carry=1, overflow=0. Then a=50, b=80, sub=1, cin=1 (cin ignored) → sum=226, carry=0 (borrow), overflow=0.
3. Defaults (32/8): a=0xFFFFFFFF, b=0, cin=1 → carry ripples through all 4 slices. sum=0, carry=1, overflow=0, done 4 cycles after start. Also a=0x7FFFFFFF, b=1 → sum=0x80000000, overflow=1, carry=0.
4. Defaults: start held high continuously with new operands each operation → results every 5 cycles. Start pulses during RUN are provably ignored: the sampled operands' result matches, not the later ones.
5. Defaults: assert rst asynchronously (between edges) during the 3rd RUN cycle → busy/done/sum/carry/overflow are 0 immediately. No done pulse follows. A following start computes correctly.
6. WIDTH=8, CHUNK=1 and WIDTH=8, CHUNK=8: sweep the ten 8-bit operand sets (100/100/1, 200/200/0, 20/200/0, 30/200/0, 40/200/1, 50/200/0, 50/90/1, 50/80/0, 50/70/0, 60/200/0) → sum, carry and overflow match the golden model, with latencies of 8 and 1 cycles respectively.
